systolic_skew_buf: RTL and testbench

Parametrised, valid-tracked skew buffer that feeds one operand matrix into the systolic MAC array. Each lane is a delay line whose depth depends on the lane index, producing the parallelogram schedule the array needs. Per-lane valid bits travel with the data, so lanes that have not yet received real data output zero instead of stale contents. This block supersedes the fixed-FIFO B-operand loader. It adds a skew-direction mode for input skew or output deskew, stall, synchronous flush, and an in-flight counter.

---
 rtl/systolic_skew_buf_pkg.sv | 21 ++
 rtl/systolic_skew_buf_if.sv | 38 +++
 rtl/systolic_skew_buf_lane.sv | 53 +++++
 rtl/systolic_skew_buf.sv | 72 +++++++
 tb/tb_systolic_skew_buf.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_skew_buf_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic array operand loaders and result
// deskewer: default element width and array dimension, the signed element
// type, and the lane delay function that produces the parallelogram schedule.
// -----------------------------------------------------------------------------
package systolic_pkg;

    localparam int DEFAULT_BITS_AB = 8;
    localparam int DEFAULT_DIM     = 8;

    typedef logic signed [DEFAULT_BITS_AB-1:0] elem_t;

    // Delay of lane i. skew_dir 0 makes lane 0 the shortest (input skew),
    // skew_dir 1 makes lane dim-1 the shortest (output deskew).
    function automatic int lane_depth(input int i, input int base_depth,
                                      input int dim, input int skew_dir);
        return (skew_dir == 0) ? (base_depth + i) : (base_depth + (dim - 1 - i));
    endfunction

endpackage

// File: rtl/systolic_skew_buf_if.sv
// -----------------------------------------------------------------------------
// systolic_skew_buf_if
// Control and data bundle of the skew buffer.
//   en, flush, valid_in, Bin : driven by the loader (master)
//   Bout, valid_out          : per-lane tail data / valid
//   busy, inflight           : occupancy status
// Bin/Bout elements are two's-complement values of BITS_AB bits each;
// element i sits at Bin[i] / Bout[i].
// -----------------------------------------------------------------------------
interface systolic_skew_buf_if
    import systolic_pkg::*;
#(
    parameter int BITS_AB    = DEFAULT_BITS_AB,
    parameter int DIM        = DEFAULT_DIM,
    parameter int BASE_DEPTH = DIM
);
    localparam int CNT_W = $clog2(BASE_DEPTH + DIM + 1);

    logic                          en;
    logic                          flush;
    logic                          valid_in;
    logic [DIM-1:0][BITS_AB-1:0]   Bin;
    logic [DIM-1:0][BITS_AB-1:0]   Bout;
    logic [DIM-1:0]                valid_out;
    logic                          busy;
    logic [CNT_W-1:0]              inflight;

    modport master (
        output en, flush, valid_in, Bin,
        input  Bout, valid_out, busy, inflight
    );

    modport slave (
        input  en, flush, valid_in, Bin,
        output Bout, valid_out, busy, inflight
    );

endinterface

// File: rtl/systolic_skew_buf_lane.sv
// -----------------------------------------------------------------------------
// skew_lane
// One lane of the skew buffer: a DEPTH-stage chain of {valid, data}.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : shift enable (0 holds every stage)
//   flush      : synchronous clear, wins over en
//   vin, din   : stage-0 load value
//   vout, dout : tail valid and tail data (data forced to 0 when not valid)
//   any_valid  : some stage of this lane holds a valid element
// -----------------------------------------------------------------------------
module skew_lane
    import systolic_pkg::*;
#(
    parameter int DEPTH   = 1,
    parameter int BITS_AB = DEFAULT_BITS_AB
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               flush,
    input  logic               vin,
    input  logic [BITS_AB-1:0] din,
    output logic               vout,
    output logic [BITS_AB-1:0] dout,
    output logic               any_valid
);

    logic [DEPTH-1:0]              valid_q;
    logic [DEPTH-1:0][BITS_AB-1:0] data_q;

    // Bubbles are stored as {0,0} so no stale operand ever sits in the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= '0;
            data_q  <= '0;
        end else if (en) begin
            valid_q[0] <= vin;
            data_q[0]  <= vin ? din : '0;
            for (int k = 1; k < DEPTH; k++) begin
                valid_q[k] <= valid_q[k-1];
                data_q[k]  <= data_q[k-1];
            end
        end
    end

    assign vout      = valid_q[DEPTH-1];
    assign dout      = valid_q[DEPTH-1] ? data_q[DEPTH-1] : '0;
    assign any_valid = |valid_q;

endmodule

// File: rtl/systolic_skew_buf.sv
// -----------------------------------------------------------------------------
// systolic_skew_buf
// Valid-tracked skew buffer feeding one operand matrix into the systolic MAC
// array. Lane i delays its element by lane_depth(i) enabled cycles.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of systolic_skew_buf_if (en, flush, valid_in, Bin in;
//           Bout, valid_out, busy, inflight out)
// -----------------------------------------------------------------------------
module systolic_skew_buf
    import systolic_pkg::*;
#(
    parameter int BITS_AB    = DEFAULT_BITS_AB,
    parameter int DIM        = DEFAULT_DIM,
    parameter int BASE_DEPTH = DIM,
    parameter int SKEW_DIR   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    systolic_skew_buf_if.slave bus
);

    localparam int CNT_W     = $clog2(BASE_DEPTH + DIM + 1);
    localparam int LONG_LANE = (SKEW_DIR == 0) ? (DIM - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DIM-1:0]              tail_valid;
    logic [DIM-1:0][BITS_AB-1:0] tail_data;
    logic [DIM-1:0]              lane_busy;
    logic [CNT_W-1:0]            inflight_q;

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        skew_lane #(
            .DEPTH   (lane_depth(i, BASE_DEPTH, DIM, SKEW_DIR)),
            .BITS_AB (BITS_AB)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (bus.en),
            .flush     (bus.flush),
            .vin       (bus.valid_in),
            .din       (bus.Bin[i]),
            .vout      (tail_valid[i]),
            .dout      (tail_data[i]),
            .any_valid (lane_busy[i])
        );
    end

    // The longest lane sees every accepted vector last, so counting entries
    // into stage 0 against exits from its tail gives the vectors in flight.
    // Simultaneous accept and exit leave the count unchanged; the count is
    // bounded by the longest lane depth and cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else if (bus.flush) begin
            inflight_q <= '0;
        end else if (bus.en) begin
            case ({bus.valid_in, tail_valid[LONG_LANE]})
                2'b10:   inflight_q <= inflight_q + CNT_ONE;
                2'b01:   inflight_q <= inflight_q - CNT_ONE;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    assign bus.Bout      = tail_data;
    assign bus.valid_out = tail_valid;
    assign bus.busy      = |lane_busy;
    assign bus.inflight  = inflight_q;

endmodule

// File: tb/tb_systolic_skew_buf.sv
// -----------------------------------------------------------------------------
// tb_systolic_skew_buf
// Drives two skew buffers (input skew and output deskew) with the same
// directed stimulus and checks them against a history-based reference model.
// -----------------------------------------------------------------------------
module tb_systolic_skew_buf;

    localparam int BITS = 8;
    localparam int DIM  = 4;
    localparam int BASE = 4;
    localparam int DMAX = BASE + DIM - 1;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    // Reference model: every enabled edge appends the offered vector to a
    // history; a lane of depth D shows the entry taken D enabled edges ago.
    // Flush and reset invalidate everything recorded before them.
    bit          hist_v [1024];
    logic [31:0] hist_d [1024];
    int          n         = 0;
    int          clear_idx = 0;
    int          seen_bad  = 0;
    int          max_infl  = 0;

    systolic_skew_buf_if #(.BITS_AB(BITS), .DIM(DIM), .BASE_DEPTH(BASE)) bus0 ();
    systolic_skew_buf_if #(.BITS_AB(BITS), .DIM(DIM), .BASE_DEPTH(BASE)) bus1 ();

    systolic_skew_buf #(.BITS_AB(BITS), .DIM(DIM), .BASE_DEPTH(BASE), .SKEW_DIR(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    systolic_skew_buf #(.BITS_AB(BITS), .DIM(DIM), .BASE_DEPTH(BASE), .SKEW_DIR(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lane_delay(input int s, input int i);
        return (s == 0) ? (BASE + i) : (BASE + DIM - 1 - i);
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic e, input logic f, input logic v,
                                  input logic [7:0] b0, input logic [7:0] b1,
                                  input logic [7:0] b2, input logic [7:0] b3);
        bus0.en = e; bus0.flush = f; bus0.valid_in = v; bus0.Bin = {b3, b2, b1, b0};
        bus1.en = e; bus1.flush = f; bus1.valid_in = v; bus1.Bin = {b3, b2, b1, b0};
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_all(input logic [7:0] val);
        apply_stimulus(1'b1, 1'b0, 1'b1, val, val, val, val);
    endtask

    task automatic bubbles(input int count);
        for (int k = 0; k < count; k++)
            apply_stimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic compare_dut(input int s, input logic [31:0] bout,
                               input logic [3:0] vout, input logic busy,
                               input logic [3:0] infl);
        int j;
        int cnt;
        bit ev;
        int ed;
        for (int i = 0; i < DIM; i++) begin
            j  = n - lane_delay(s, i);
            ev = 1'b0;
            ed = 0;
            if (j >= 0 && j >= clear_idx) begin
                ev = hist_v[j];
                if (ev) ed = int'(hist_d[j][8*i +: 8]);
            end
            check_output($sformatf("dut%0d valid_out[%0d]", s, i), int'(vout[i]), int'(ev));
            check_output($sformatf("dut%0d Bout[%0d]", s, i), int'(bout[8*i +: 8]), ed);
            if (vout[i] && (bout[8*i +: 8] == 8'd99 || bout[8*i +: 8] == 8'd77))
                seen_bad++;
        end
        cnt = 0;
        for (int k = n - DMAX; k < n; k++)
            if (k >= 0 && k >= clear_idx && hist_v[k]) cnt++;
        check_output($sformatf("dut%0d inflight", s), int'(infl), cnt);
        check_output($sformatf("dut%0d busy", s), int'(busy), int'(cnt > 0));
        if (int'(infl) > max_infl) max_infl = int'(infl);
    endtask

    // Model update on every clock edge and on asynchronous reset assertion.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                clear_idx = n;
            end else if (bus0.flush) begin
                clear_idx = n;
            end else if (bus0.en) begin
                hist_v[n] = bus0.valid_in;
                hist_d[n] = bus0.Bin;
                n++;
            end
        end
    end

    // Continuous comparison on the falling edge, away from state updates.
    initial begin
        forever begin
            @(negedge clk);
            compare_dut(0, bus0.Bout, bus0.valid_out, bus0.busy, bus0.inflight);
            compare_dut(1, bus1.Bout, bus1.valid_out, bus1.busy, bus1.inflight);
        end
    end

    initial begin
        rst_n = 1'b0;
        bus0.en = 1'b1; bus0.flush = 1'b0; bus0.valid_in = 1'b0; bus0.Bin = '0;
        bus1.en = 1'b1; bus1.flush = 1'b0; bus1.valid_in = 1'b0; bus1.Bin = '0;
        repeat (2) @(negedge clk);
        check_output("reset busy", int'(bus0.busy), 0);
        check_output("reset valid_out", int'(bus0.valid_out), 0);
        check_output("reset inflight", int'(bus1.inflight), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single vector {1,2,3,4}
        apply_stimulus(1'b1, 1'b0, 1'b1, 8'd1, 8'd2, 8'd3, 8'd4);
        check_output("single inflight after accept", int'(bus0.inflight), 1);
        bubbles(2);
        check_output("single lane0 not yet valid", int'(bus0.valid_out[0]), 0);
        bubbles(1);
        check_output("skew0 lane0 at 4", int'(bus0.Bout[0]), 1);
        check_output("skew0 lane1 still 0 at 4", int'(bus0.Bout[1]), 0);
        check_output("skew1 lane3 at 4", int'(bus1.Bout[3]), 4);
        bubbles(1);
        check_output("skew0 lane1 at 5", int'(bus0.Bout[1]), 2);
        bubbles(2);
        check_output("skew0 lane3 at 7", int'(bus0.Bout[3]), 4);
        check_output("skew1 lane0 at 7", int'(bus1.Bout[0]), 1);
        check_output("skew0 lane0 back to 0", int'(bus0.Bout[0]), 0);
        check_output("single inflight at 7", int'(bus0.inflight), 1);
        bubbles(1);
        check_output("single inflight drained", int'(bus0.inflight), 0);
        check_output("single busy drained", int'(bus1.busy), 0);
        bubbles(2);

        // Stream with a bubble: 10, 20, -, 30
        send_all(8'd10);
        send_all(8'd20);
        bubbles(1);
        send_all(8'd30);
        check_output("stream lane0 first", int'(bus0.Bout[0]), 10);
        check_output("stream inflight peak", int'(bus0.inflight), 3);
        bubbles(1);
        check_output("stream lane0 second", int'(bus0.Bout[0]), 20);
        bubbles(1);
        check_output("stream lane0 bubble valid", int'(bus0.valid_out[0]), 0);
        check_output("stream lane0 bubble data", int'(bus0.Bout[0]), 0);
        bubbles(1);
        check_output("stream lane0 third", int'(bus0.Bout[0]), 30);
        check_output("stream lane3 first", int'(bus0.Bout[3]), 10);
        bubbles(8);

        // Stall mid-stream: inputs offered while en=0 are dropped
        send_all(8'd41); send_all(8'd42); send_all(8'd43); send_all(8'd44); send_all(8'd45);
        check_output("prestall lane0", int'(bus0.Bout[0]), 42);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, 8'd99, 8'd99, 8'd99, 8'd99);
            check_output("stall lane0 frozen", int'(bus0.Bout[0]), 42);
            check_output("stall inflight frozen", int'(bus0.inflight), 5);
        end
        bubbles(1);
        check_output("resume lane0", int'(bus0.Bout[0]), 43);
        bubbles(2);
        check_output("resume lane0 last", int'(bus0.Bout[0]), 45);
        bubbles(8);

        // Flush colliding with en and valid_in while busy
        send_all(8'd50);
        send_all(8'd51);
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'd77, 8'd77, 8'd77, 8'd77);
        check_output("flush busy", int'(bus0.busy), 0);
        check_output("flush inflight", int'(bus1.inflight), 0);
        check_output("flush valid_out", int'(bus1.valid_out), 0);
        bubbles(10);

        // Asynchronous reset mid-stream
        send_all(8'd60); send_all(8'd61); send_all(8'd62);
        bubbles(2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("async reset busy", int'(bus0.busy), 0);
        check_output("async reset Bout", int'(bus0.Bout), 0);
        check_output("async reset valid_out", int'(bus1.valid_out), 0);
        check_output("async reset inflight", int'(bus1.inflight), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_all(8'd5);
        bubbles(9);

        check_output("flushed or stalled vector emitted", seen_bad, 0);
        check_output("inflight within bound", int'(max_infl <= DMAX), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
